// File: rtl/pc_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit_if
// Purpose  : Program-memory fetch bus between the PC/fetch stage and the
//            instruction memory. A request is held until the memory
//            acknowledges it; read data is valid only in the ack cycle.
// Signals  :
//   mem_req    fetch request (master -> slave)
//   mem_addr   fetch address, held stable while mem_req=1 (master -> slave)
//   mem_ack    read data valid this cycle (slave -> master)
//   mem_rdata  instruction word (slave -> master)
// Modports : master (fetch unit), slave (program memory)
// Revision : 1.0 - initial release
// ============================================================================
interface pc_fetch_unit_if #(
  parameter int PC_WIDTH          = 8,
  parameter int PROGRAM_DataWidth = 16
);

  logic                         mem_req;
  logic [PC_WIDTH-1:0]          mem_addr;
  logic                         mem_ack;
  logic [PROGRAM_DataWidth-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );

endinterface : pc_fetch_unit_if
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Purpose  : Program counter and instruction fetch stage feeding the
//            instruction decoder. Fetches one word per instruction over a
//            req/ack bus, holds it in the instruction register, pulses
//            instr_valid for the single execute cycle and then advances the
//            PC by increment, absolute jump or PC-relative branch.
// Ports    :
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   mem          program-memory fetch bus (master side)
//   instruction  instruction register, to decoder
//   instr_valid  high for the execute cycle of the current instruction
//   cnt_wr_en    decoder: load PC instead of incrementing
//   add_offset   decoder: load is relative (pc + sext(literal_adr))
//   literal_adr  decoder: absolute target or signed 8-bit offset
//   halt         stop fetching after the current instruction
//   halted       unit is parked in HALT
//   pc           current program counter
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
  parameter int                  PC_WIDTH          = 8,
  parameter int                  PROGRAM_DataWidth = 16,
  parameter logic [PC_WIDTH-1:0] ResetVector       = '0
) (
  input  wire logic                         clk,
  input  wire logic                         rst_n,
  pc_fetch_unit_if.master                   mem,
  output logic [PROGRAM_DataWidth-1:0]      instruction,
  output logic                              instr_valid,
  input  wire logic                         cnt_wr_en,
  input  wire logic                         add_offset,
  input  wire logic [7:0]                   literal_adr,
  input  wire logic                         halt,
  output logic                              halted,
  output logic [PC_WIDTH-1:0]               pc
);

  localparam logic [1:0] c_st_fetch = 2'd0;
  localparam logic [1:0] c_st_exec  = 2'd1;
  localparam logic [1:0] c_st_halt  = 2'd2;

  localparam logic [PC_WIDTH-1:0] c_pc_one = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]                   r_state;
  logic [1:0]                   w_state_next;
  logic [PC_WIDTH-1:0]          r_pc;
  logic [PC_WIDTH-1:0]          w_pc_next;
  logic [PC_WIDTH-1:0]          w_abs_target;
  logic [PC_WIDTH-1:0]          w_rel_offset;
  logic [PROGRAM_DataWidth-1:0] r_instr;
  logic                         r_req;
  logic                         r_valid;
  logic                         r_halted;
  logic                         w_accept;

  // The decoder literal is 8 bits; fit it to the PC width. Absolute targets
  // are zero-extended, relative offsets sign-extended. For narrow PCs plain
  // truncation is still correct modulo 2^PC_WIDTH.
  generate
    if (PC_WIDTH > 8) begin : g_wide_pc
      assign w_abs_target = {{(PC_WIDTH-8){1'b0}}, literal_adr};
      assign w_rel_offset = {{(PC_WIDTH-8){literal_adr[7]}}, literal_adr};
    end else begin : g_narrow_pc
      assign w_abs_target = literal_adr[PC_WIDTH-1:0];
      assign w_rel_offset = literal_adr[PC_WIDTH-1:0];
    end
  endgenerate

  // The request flag is registered and cleared by reset, so a word is only
  // accepted while the request is actually visible on the bus. This also
  // makes any ack outside FETCH harmless.
  assign w_accept = r_req & mem.mem_ack;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_fetch: if (w_accept) w_state_next = c_st_exec;
      c_st_exec:  w_state_next = halt ? c_st_halt : c_st_fetch;
      c_st_halt:  if (!halt) w_state_next = c_st_fetch;
      default:    w_state_next = c_st_fetch;
    endcase
  end

  // Relative branches are taken from the address of the branch itself,
  // which is still in r_pc during the execute cycle. Wrap is silent.
  always_comb begin
    w_pc_next = r_pc + c_pc_one;
    if (cnt_wr_en) begin
      if (add_offset) begin
        w_pc_next = r_pc + w_rel_offset;
      end else begin
        w_pc_next = w_abs_target;
      end
    end
  end

  // Status outputs are registered copies of the next state so they are
  // glitch-free and all read 0 while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_st_fetch;
      r_pc     <= ResetVector;
      r_instr  <= '0;
      r_req    <= 1'b0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_req    <= (w_state_next == c_st_fetch);
      r_valid  <= (w_state_next == c_st_exec);
      r_halted <= (w_state_next == c_st_halt);
      if (w_accept) begin
        r_instr <= mem.mem_rdata;
      end
      // PC moves only at the end of the execute cycle, whether or not the
      // unit halts afterwards.
      if (r_valid) begin
        r_pc <= w_pc_next;
      end
    end
  end

  assign mem.mem_req  = r_req;
  assign mem.mem_addr = r_pc;
  assign instruction  = r_instr;
  assign instr_valid  = r_valid;
  assign halted       = r_halted;
  assign pc           = r_pc;

endmodule : pc_fetch_unit
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_unit
// Purpose  : Self-checking bench for pc_fetch_unit. The bench plays both the
//            program memory (configurable ack latency) and the decoder
//            (word[15]=cnt_wr_en, word[14]=add_offset, word[7:0]=literal).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [15:0] instruction;
  logic        instr_valid;
  logic        cnt_wr_en;
  logic        add_offset;
  logic [7:0]  literal_adr;
  logic        halt;
  logic        halted;
  logic [7:0]  pc;

  pc_fetch_unit_if #(.PC_WIDTH(8), .PROGRAM_DataWidth(16)) bus ();

  pc_fetch_unit #(
    .PC_WIDTH(8),
    .PROGRAM_DataWidth(16),
    .ResetVector(8'h00)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mem(bus.master),
    .instruction(instruction),
    .instr_valid(instr_valid),
    .cnt_wr_en(cnt_wr_en),
    .add_offset(add_offset),
    .literal_adr(literal_adr),
    .halt(halt),
    .halted(halted),
    .pc(pc)
  );

  // Decoder stand-in
  assign cnt_wr_en   = instruction[15];
  assign add_offset  = instruction[14];
  assign literal_adr = instruction[7:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_err;
  int          n_checks;
  logic [15:0] mem [256];
  int          wait_cnt;
  int          cur_delay;
  int          fixed_delay;
  bit          rand_delay;
  bit          acked;
  logic [7:0]  acked_addr;
  logic [15:0] acked_word;

  typedef struct {
    logic [7:0]  start;
    logic [15:0] word;
    logic [7:0]  exp_next;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference next-PC rule, straight integer arithmetic modulo 256.
  function automatic logic [7:0] ref_next_pc(input logic [7:0] p, input logic [15:0] w);
    int t;
    if (!w[15])      t = int'(p) + 1;
    else if (!w[14]) t = int'(w[7:0]);
    else             t = int'(p) + int'($signed(w[7:0]));
    return t[7:0];
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  // Memory responder, evaluated once per cycle just after the rising edge.
  task automatic drive_mem();
    acked = 1'b0;
    if (bus.mem_req) begin
      if (wait_cnt >= cur_delay) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem[bus.mem_addr];
        acked         = 1'b1;
        acked_addr    = bus.mem_addr;
        acked_word    = mem[bus.mem_addr];
        wait_cnt      = 0;
        cur_delay     = rand_delay ? int'($urandom_range(0, 3)) : fixed_delay;
      end else begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'($urandom);
        wait_cnt++;
      end
    end else begin
      bus.mem_ack   = 1'($urandom);
      bus.mem_rdata = 16'($urandom);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    drive_mem();
  endtask

  task automatic reset_dut(input bit check_reset);
    rst_n       = 1'b0;
    halt        = 1'b0;
    bus.mem_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    if (check_reset) begin
      chk("rst_pc", pc, 8'h00);
      chk("rst_instr", instruction, 16'h0000);
      chk("rst_req", bus.mem_req, 1'b0);
      chk("rst_valid", instr_valid, 1'b0);
      chk("rst_halted", halted, 1'b0);
    end
    @(negedge clk);
    rst_n       = 1'b1;
    bus.mem_ack = 1'b0;
    wait_cnt    = 0;
    cur_delay   = fixed_delay;
    acked       = 1'b0;
  endtask

  initial begin
    n_err       = 0;
    n_checks    = 0;
    rst_n       = 1'b1;
    halt        = 1'b0;
    fixed_delay = 0;
    rand_delay  = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'h0000;
    wait_cnt    = 0;
    cur_delay   = 0;
    acked       = 1'b0;
    acked_addr  = 8'h00;
    acked_word  = 16'h0000;

    vecs[0] = '{8'h03, 16'h8040, 8'h40};  // absolute jump
    vecs[1] = '{8'h10, 16'hC0FC, 8'h0C};  // branch back 4
    vecs[2] = '{8'h10, 16'hC005, 8'h15};  // branch forward 5
    vecs[3] = '{8'hFF, 16'h0000, 8'h00};  // increment wraps
    vecs[4] = '{8'hFE, 16'hC004, 8'h02};  // relative wraps
    vecs[5] = '{8'h80, 16'hC080, 8'h00};  // most negative offset
    vecs[6] = '{8'h20, 16'h8000, 8'h00};  // jump to zero
    vecs[7] = '{8'h05, 16'hC0FB, 8'h00};  // back to start of memory

    #2;

    // ---- Reset state, then back-to-back NOP stream with ack tied high ----
    clear_mem();
    reset_dut(1'b1);
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("nop_req", bus.mem_req, (k % 2 == 0));
      chk("nop_valid", instr_valid, (k % 2 == 1));
      if (k % 2 == 0) chk("nop_addr", bus.mem_addr, 8'(k / 2));
    end

    // ---- Table-driven next-PC vectors ----
    for (int v = 0; v < 8; v++) begin
      bit found;
      clear_mem();
      mem[0]             = 16'h8000 | {8'h00, vecs[v].start};
      mem[vecs[v].start] = vecs[v].word;
      fixed_delay        = 0;
      reset_dut(1'b0);
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
        cyc();
        if (acked && acked_addr == vecs[v].start) found = 1'b1;
      end
      chk("vec_reach", found, 1'b1);
      if (found) begin
        cyc();
        chk("vec_exec_valid", instr_valid, 1'b1);
        chk("vec_exec_instr", instruction, vecs[v].word);
        cyc();
        chk("vec_next_req", bus.mem_req, 1'b1);
        chk("vec_next_addr", bus.mem_addr, vecs[v].exp_next);
      end
    end

    // ---- Ack delayed by 3 cycles ----
    clear_mem();
    mem[0]      = 16'h1234;
    fixed_delay = 3;
    reset_dut(1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("wait_req", bus.mem_req, 1'b1);
      chk("wait_addr", bus.mem_addr, 8'h00);
      chk("wait_valid", instr_valid, 1'b0);
      chk("wait_instr", instruction, 16'h0000);
    end
    cyc();
    chk("wait_exec_valid", instr_valid, 1'b1);
    chk("wait_exec_instr", instruction, 16'h1234);
    chk("wait_exec_req", bus.mem_req, 1'b0);
    cyc();
    chk("wait_next_addr", bus.mem_addr, 8'h01);

    // ---- Halt, resume, and reset in the middle of a fetch ----
    clear_mem();
    fixed_delay = 0;
    reset_dut(1'b0);
    cyc();
    cyc();
    chk("halt_exec_valid", instr_valid, 1'b1);
    halt = 1'b1;
    cyc();
    chk("halt_halted", halted, 1'b1);
    chk("halt_pc", pc, 8'h01);
    chk("halt_req", bus.mem_req, 1'b0);
    chk("halt_valid", instr_valid, 1'b0);
    cyc();
    chk("halt_hold", halted, 1'b1);
    chk("halt_hold_pc", pc, 8'h01);
    halt      = 1'b0;
    cur_delay = 5;
    wait_cnt  = 0;
    cyc();
    chk("resume_halted", halted, 1'b0);
    chk("resume_req", bus.mem_req, 1'b1);
    chk("resume_addr", bus.mem_addr, 8'h01);
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_req", bus.mem_req, 1'b0);
    chk("midrst_pc", pc, 8'h00);
    chk("midrst_valid", instr_valid, 1'b0);
    reset_dut(1'b0);
    cyc();
    chk("postrst_addr", bus.mem_addr, 8'h00);
    chk("postrst_valid", instr_valid, 1'b0);

    // ---- Randomized run against the reference model ----
    begin
      logic [7:0]  model_pc;
      logic [15:0] last_word;
      bit          exp_valid;
      bit          exp_halted;
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      rand_delay  = 1'b1;
      fixed_delay = 1;
      reset_dut(1'b0);
      model_pc   = 8'h00;
      last_word  = 16'h0000;
      exp_valid  = 1'b0;
      exp_halted = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        cyc();
        chk("rnd_valid", instr_valid, exp_valid);
        chk("rnd_halted", halted, exp_halted);
        chk("rnd_req", bus.mem_req, !exp_valid && !exp_halted);
        chk("rnd_pc", pc, model_pc);
        chk("rnd_instr", instruction, last_word);
        if (!exp_valid && !exp_halted) chk("rnd_addr", bus.mem_addr, model_pc);
        if (exp_valid) begin
          halt       = ($urandom_range(0, 3) == 0);
          model_pc   = ref_next_pc(model_pc, last_word);
          exp_halted = halt;
          exp_valid  = 1'b0;
        end else if (exp_halted) begin
          halt       = ($urandom_range(0, 2) != 0);
          exp_halted = halt;
        end else begin
          halt      = 1'($urandom);
          exp_valid = acked;
          if (acked) last_word = acked_word;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_pc_fetch_unit
`default_nettype wire
